// File: rtl/dot_frame_buffer.sv
// Double-buffered 8x8 dot-matrix frame store.
// The producer writes rows into the back bank and requests a commit. The banks
// swap only on a scanner frame_end, so a frame is never shown half-old and
// half-new. Reads give a registered front-bank byte, rotated left by the
// scroll offset.
module dot_frame_buffer #(
  parameter int SCROLL_FRAMES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic       frame_end,
  input  logic       scroll_en,
  input  logic [2:0] rd_row,
  output logic [7:0] rd_data,
  output logic       commit_pending,
  output logic       swap_done
);

  localparam int FCNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(SCROLL_FRAMES - 1);

  // Both banks live in one 16-entry array. The address is {bank, row}.
  logic [7:0]        mem_reg [16];
  logic              bank_reg;
  logic [2:0]        offset_reg;
  logic [2:0]        offset_next;
  logic [FCNT_W-1:0] fcnt_reg;
  logic [FCNT_W-1:0] fcnt_next;
  logic [7:0]        rd_data_reg;
  logic [7:0]        rd_data_next;
  logic              commit_pending_reg;
  logic              swap_done_reg;

  logic              swap;
  logic              scroll_tick;
  logic [7:0]        front_byte;

  // A commit arriving together with frame_end swaps straight away.
  assign swap        = frame_end & (commit_pending_reg | commit);
  assign scroll_tick = frame_end & scroll_en & ~swap;
  assign front_byte  = mem_reg[{bank_reg, rd_row}];

  // Rotate left by offset: output bit i takes input bit (i - offset) mod 8.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rot
      localparam logic [2:0] BIT_IDX = gi;
      assign rd_data_next[gi] = front_byte[BIT_IDX - offset_reg];
    end
  endgenerate

  // Back-bank write. It uses the pre-edge bank, so a write on the swap edge
  // becomes part of the newly displayed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_en) begin
      mem_reg[{~bank_reg, wr_row}] <= wr_data;
    end
  end

  // Scroll counter. A swap clears the counter and the offset, and takes
  // priority over a scroll step due on the same edge.
  always_comb begin
    fcnt_next   = fcnt_reg;
    offset_next = offset_reg;
    if (swap) begin
      fcnt_next   = '0;
      offset_next = '0;
    end else if (scroll_tick) begin
      if (fcnt_reg == FCNT_LAST) begin
        fcnt_next   = '0;
        offset_next = offset_reg + 3'd1;
      end else begin
        fcnt_next = fcnt_reg + FCNT_W'(1);
      end
    end
  end

  // Bank select, commit handshake, scroll state and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_reg           <= 1'b0;
      offset_reg         <= '0;
      fcnt_reg           <= '0;
      rd_data_reg        <= '0;
      commit_pending_reg <= 1'b0;
      swap_done_reg      <= 1'b0;
    end else begin
      rd_data_reg   <= rd_data_next;
      offset_reg    <= offset_next;
      fcnt_reg      <= fcnt_next;
      swap_done_reg <= swap;
      if (swap) begin
        bank_reg           <= ~bank_reg;
        commit_pending_reg <= 1'b0;
      end else if (commit) begin
        commit_pending_reg <= 1'b1;
      end
    end
  end

  assign rd_data        = rd_data_reg;
  assign commit_pending = commit_pending_reg;
  assign swap_done      = swap_done_reg;

endmodule

// File: tb/tb_dot_frame_buffer.sv
// Bench for dot_frame_buffer. A frame-level reference model keeps a displayed
// and a staged image and exchanges them on swap. The scroll offset is derived
// from the number of counted frames since the last swap.
module tb_dot_frame_buffer;

  localparam int SF = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [7:0] wr_data;
  logic       commit;
  logic       frame_end;
  logic       scroll_en;
  logic [2:0] rd_row;
  logic [7:0] rd_data;
  logic       commit_pending;
  logic       swap_done;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] disp  [8];
  logic [7:0] stage [8];
  bit         m_pend;
  bit         m_sd;
  logic [7:0] m_rd;
  int         steps;

  always #5 clk = ~clk;

  dot_frame_buffer #(.SCROLL_FRAMES(SF)) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_en          (wr_en),
    .wr_row         (wr_row),
    .wr_data        (wr_data),
    .commit         (commit),
    .frame_end      (frame_end),
    .scroll_en      (scroll_en),
    .rd_row         (rd_row),
    .rd_data        (rd_data),
    .commit_pending (commit_pending),
    .swap_done      (swap_done)
  );

  function automatic logic [7:0] rotl8(input logic [7:0] d, input int k);
    logic [15:0] t;
    t = {d, d} << k;
    return t[15:8];
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      disp[i]  = 8'h00;
      stage[i] = 8'h00;
    end
    m_pend = 0;
    m_sd   = 0;
    m_rd   = 8'h00;
    steps  = 0;
  endtask

  // One clock edge of the model, using the input values the DUT sampled.
  task automatic model_edge();
    logic [7:0] rd_new;
    logic [7:0] tmp;
    bit         sw;
    if (!rst) begin
      model_reset();
      return;
    end
    sw     = frame_end && (m_pend || commit);
    rd_new = rotl8(disp[rd_row], (steps / SF) % 8);
    if (wr_en) stage[wr_row] = wr_data;
    if (sw) begin
      for (int i = 0; i < 8; i++) begin
        tmp      = disp[i];
        disp[i]  = stage[i];
        stage[i] = tmp;
      end
      m_pend = 0;
      steps  = 0;
      m_sd   = 1;
    end else begin
      m_sd = 0;
      if (commit) m_pend = 1;
      if (frame_end && scroll_en) steps++;
    end
    m_rd = rd_new;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_val("rd_data", rd_data, m_rd);
    check_val("commit_pending", commit_pending, m_pend);
    check_val("swap_done", swap_done, m_sd);
  endtask

  task automatic cyc(input bit we, input logic [2:0] wrow, input logic [7:0] wd,
                     input bit cm, input bit fe, input bit se, input logic [2:0] rr);
    wr_en     = we;
    wr_row    = wrow;
    wr_data   = wd;
    commit    = cm;
    frame_end = fe;
    scroll_en = se;
    rd_row    = rr;
    tick();
    $display("cyc t=%0t we=%0b wr=%0d:%02h cm=%0b fe=%0b se=%0b rr=%0d -> rd=%02h pend=%0b sd=%0b",
             $time, we, wrow, wd, cm, fe, se, rr, rd_data, commit_pending, swap_done);
  endtask

  initial begin
    logic [7:0] pat [8];
    pat = '{8'h18, 8'h24, 8'h42, 8'hC3, 8'h42, 8'h42, 8'h42, 8'h7E};

    rst = 1'b0; wr_en = 0; wr_row = 0; wr_data = 0; commit = 0;
    frame_end = 0; scroll_en = 0; rd_row = 0;
    model_reset();

    // reset values
    for (int r = 0; r < 8; r++) begin
      cyc(0, 0, 0, 0, 0, 0, 3'(r));
      check_val("rst_rd", rd_data, 0);
    end
    check_val("rst_pend", commit_pending, 0);
    check_val("rst_sd", swap_done, 0);
    rst = 1'b1;

    // load and swap
    for (int r = 0; r < 8; r++) cyc(1, 3'(r), pat[r], 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    check_val("commit_pend", commit_pending, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("front_old", rd_data, 8'h00);
    cyc(0, 0, 0, 0, 1, 0, 3);
    check_val("swap_pulse", swap_done, 1);
    check_val("read_preswap", rd_data, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 3);
    check_val("row3", rd_data, 8'hC3);
    check_val("swap_once", swap_done, 0);

    // no tearing
    cyc(1, 0, 8'hFF, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check_val("no_swap", swap_done, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("no_tear", rd_data, 8'h18);
    cyc(0, 0, 0, 1, 1, 0, 0);
    check_val("same_cyc_pend", commit_pending, 0);
    check_val("same_cyc_sd", swap_done, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("new_row0", rd_data, 8'hFF);
    cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("new_row1", rd_data, 8'h00);

    // scroll: return to the bank holding 0x18 in row 0
    cyc(0, 0, 0, 1, 1, 1, 0);
    for (int n = 1; n <= 16; n++) begin
      cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 0, 1, 0);
      if (n == 2)  check_val("scroll2", rd_data, 8'h30);
      if (n == 14) check_val("scroll14", rd_data, 8'h0C);
      if (n == 16) check_val("scroll16", rd_data, 8'h18);
    end

    // swap beats scroll: offset 3, counter at its last value, commit pending
    cyc(0, 0, 0, 1, 1, 1, 0);
    for (int n = 0; n < 7; n++) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    check_val("swap_win_sd", swap_done, 1);
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_val("swap_win_rd", rd_data, 8'h18);

    // reset mid-operation: offset 5 and a commit pending
    for (int n = 0; n < 10; n++) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 0, 1, 0);
    check_val("pre_rst_pend", commit_pending, 1);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rd", rd_data, 0);
    check_val("async_pend", commit_pending, 0);
    check_val("async_sd", swap_done, 0);
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    for (int r = 0; r < 8; r++) begin
      cyc(0, 0, 0, 0, 0, 0, 3'(r));
      check_val("post_rst_rd", rd_data, 0);
    end
    cyc(0, 0, 0, 0, 1, 0, 0);
    check_val("post_rst_noswap", swap_done, 0);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 8'($urandom),
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_frame_buffer.md
# dot_frame_buffer

Double-buffered 8x8 frame store feeding the LED dot-matrix row scanner directly upstream of it. A producer loads a new pattern row by row into a back bank and requests a commit. The buffer swaps banks only at a scanner frame boundary, so a frame is never displayed half-old and half-new. The scanner reads column bytes by row index with one-cycle latency, and the buffer can rotate each returned byte horizontally to scroll the image.

## Interface
- SCROLL_FRAMES, default 16: number of scanned frames per one-column scroll step; legal values are 2 to 256.
- clk  in  1  system clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe for the back bank
- wr_row  in  3  back-bank row address
- wr_data  in  8  column byte to write; bit 7 is the leftmost column
- commit  in  1  one-cycle request to publish the back bank at the next frame boundary
- frame_end  in  1  one-cycle pulse from the scanner after row 7 has been displayed
- scroll_en  in  1  level; enables the scroll step counter
- rd_row  in  3  front-bank row address requested by the scanner
- rd_data  out  8  registered, rotated front-bank byte
- commit_pending  out  1  high from an accepted commit until the swap
- swap_done  out  1  one-cycle pulse in the cycle after the swap edge

## Operation
- **Storage**
  - Two banks, each 8 x 8 bits.
  - A 1-bit `bank` register selects the front bank; the back bank is `~bank`.
- **Write**
  - When `wr_en` is high: `back[wr_row] <= wr_data`.
  - Writes are always accepted, including while `commit_pending` is high.
- **Commit**
  - When `commit` is high: `commit_pending <= 1`.
  - A repeated commit while pending has no additional effect.
- **Swap**
  - Occurs on an edge where `frame_end` is high and a commit is pending, or `commit` is high in that same cycle.
  - On that edge:
    - `bank` toggles.
    - `commit_pending` clears.
    - `swap_done` is set to 1 for one cycle.
    - The scroll offset and frame counter clear to 0.
- **Scroll**
  - `fcnt` has width clog2(SCROLL_FRAMES). `offset` is 3 bits.
  - On a `frame_end` edge with `scroll_en` high and no swap:
    - If `fcnt == SCROLL_FRAMES-1`: `fcnt` becomes 0 and `offset` becomes `offset+1` (mod 8; 7 wraps to 0).
    - Otherwise `fcnt` increments.
  - When `scroll_en` is low, `fcnt` and `offset` hold. Deasserting `scroll_en` does not reset them.
- **Read**
  - `rd_data <= rotl8(front[rd_row], offset)`, computed from the pre-edge values of `bank` and `offset`.
  - `rotl8(d, k) = ({d, d} << k)[15:8]`. Example: `rotl8(8'b00011000, 1) = 8'b00110000`.
- **Simultaneous events**
  - Write and swap in the same edge: the write lands in the pre-edge back bank, so it becomes part of the newly displayed frame.
  - Read and swap in the same edge: the read returns pre-swap front data.
  - `commit` and `frame_end` in the same cycle: the swap happens that edge, and `commit_pending` never rises.
  - Swap and scroll step due on the same edge: the swap wins; `offset` and `fcnt` go to 0.
- **Reset** (asynchronous, while `rst` is 0):
  - Both banks are all-zero.
  - `bank`, `offset`, `fcnt`, `rd_data`, `commit_pending` and `swap_done` are 0.
  - Reset mid-write or with a commit pending discards the pending commit and all stored data.

## Timing
- Read latency is 1 cycle: `rd_row` presented at edge N gives `rd_data` valid after edge N, through the next edge.
- `commit_pending` rises the edge after `commit`. It stays high until the edge that samples the next `frame_end`.
- `swap_done` is high exactly one cycle, after the swap edge.
- A write at edge N is readable from the front bank only after a swap at an edge after N, or at N itself per the same-edge rule.
- Scroll period is SCROLL_FRAMES `frame_end` pulses per column step, for a full 8-step cycle of 8*SCROLL_FRAMES frames.
- No combinational path from any input to any output.

## Test plan
1. **Reset values:** hold `rst` low and drive `rd_row` 0..7 -> `rd_data` = 0x00 for every row; `commit_pending` = 0 and `swap_done` = 0.
2. **Load and swap:** write rows 0..7 = 18,24,42,C3,42,42,42,7E (hex), then pulse `commit` -> `commit_pending` = 1 and front still reads 0x00. Pulse `frame_end` -> `swap_done` pulses once, and reading row 3 returns 0xC3 one cycle later.
3. **No tearing:** after step 2, write row 0 = 0xFF without `commit`, then pulse `frame_end` -> row 0 still reads 0x18. Then pulse `commit` and `frame_end` in the same cycle -> swap on that edge, `commit_pending` stays 0, and row 0 reads 0xFF. Because the banks alternate, rows 1..7 read 0x00, since that bank was never written.
4. **Scroll:** SCROLL_FRAMES=2, `scroll_en`=1, row 0 = 0x18 -> after 2 `frame_end` pulses row 0 reads 0x30, after 14 pulses reads 0x0C, and after 16 pulses reads 0x18 (wrap).
5. **Swap beats scroll:** with offset 3, `fcnt` = SCROLL_FRAMES-1, and a commit pending, pulse `frame_end` -> the new bank is read with offset 0, not 4.
6. **Reset mid-operation:** with a commit pending and offset 5, assert `rst` asynchronously between edges -> all outputs are 0 immediately. After release, reading any row returns 0x00 and `frame_end` causes no swap.
